mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline stage for the RV32 core. It replaces the bare MEM/WB signal bundle with a buffered, flow-controlled stage: a valid/ready handshake on each side, a DEPTH-entry in-order buffer, flush support and x0-write suppression. It also resolves the writeback result at the buffer head and exposes it to the hazard unit for forwarding, and keeps a saturating back-pressure counter.

---
 rtl/mem_wb_pipe_pkg.sv | 25 ++
 rtl/mem_wb_pipe_if.sv | 44 ++++
 rtl/mem_wb_fifo.sv | 74 +++++++
 rtl/mem_wb_pipe.sv | 105 ++++++++++
 tb/tb_mem_wb_pipe.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared core types for the MEM->WB stage: writeback source select,
// data word type and the buffered pipeline entry layout.
package mem_wb_pipe_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int CORE_REG_ADDR_W = 5;

    typedef logic [CORE_XLEN-1:0] data_t;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'd0,
        RESULT_MEM = 2'd1,
        RESULT_PC4 = 2'd2
    } result_src_t;

    typedef struct packed {
        result_src_t                result_src;
        logic                       reg_write;
        data_t                      read_data;
        data_t                      alu_result;
        data_t                      pc_plus4;
        logic [CORE_REG_ADDR_W-1:0] rd;
    } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM-side and WB-side handshake bundle of the MEM->WB stage plus the
// forwarding view of the buffer head.
interface mem_wb_pipe_if
    import mem_wb_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // Both sides use valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; valid must not wait for ready.
    logic                  in_valid;
    logic                  in_ready;
    result_src_t           in_result_src;
    logic                  in_reg_write;
    logic [XLEN-1:0]       in_read_data;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_pc_plus4;
    logic [REG_ADDR_W-1:0] in_rd;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_reg_write;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [XLEN-1:0]       out_result;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;

    modport slave (
        input  in_valid, in_result_src, in_reg_write, in_read_data,
               in_alu_result, in_pc_plus4, in_rd, out_ready,
        output in_ready, out_valid, out_reg_write, out_rd, out_result,
               fwd_valid, fwd_rd, fwd_data
    );

    modport master (
        output in_valid, in_result_src, in_reg_write, in_read_data,
               in_alu_result, in_pc_plus4, in_rd, out_ready,
        input  in_ready, out_valid, out_reg_write, out_rd, out_result,
               fwd_valid, fwd_rd, fwd_data
    );

endinterface

// File: rtl/mem_wb_fifo.sv
// Generic in-order DEPTH x WIDTH buffer with occupancy count, wrapping
// pointers and a synchronous flush. Storage itself is never reset.
module mem_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    generate
        if (DEPTH > 1) begin : g_ptr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else if (flush) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end else begin : g_no_ptr
            assign wr_ptr_q = '0;
            assign rd_ptr_q = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_i && !flush) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: buffers entries in order, suppresses x0 writes,
// resolves the writeback value at the head and counts back-pressure cycles.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    mem_wb_pipe_if.slave           bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        result_src_t           result_src;
        logic                  reg_write;
        logic [XLEN-1:0]       read_data;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       pc_plus4;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                 wr_entry;
    entry_t                 head_entry;
    logic [ENTRY_W-1:0]     head_bits;
    logic                   full, empty, push, pop;
    logic [XLEN-1:0]        head_result;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // in_ready depends only on occupancy, never on out_ready.
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign push          = bus.in_valid & ~full;
    assign pop           = ~empty & bus.out_ready;

    always_comb begin
        wr_entry            = '0;
        wr_entry.result_src = bus.in_result_src;
        wr_entry.reg_write  = bus.in_reg_write & (bus.in_rd != '0);
        wr_entry.read_data  = bus.in_read_data;
        wr_entry.alu_result = bus.in_alu_result;
        wr_entry.pc_plus4   = bus.in_pc_plus4;
        wr_entry.rd         = bus.in_rd;
    end

    mem_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_bits),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_entry = entry_t'(head_bits);

    always_comb begin
        head_result = '0;
        case (head_entry.result_src)
            RESULT_ALU: head_result = head_entry.alu_result;
            RESULT_MEM: head_result = head_entry.read_data;
            RESULT_PC4: head_result = head_entry.pc_plus4;
            default:    head_result = '0;
        endcase
    end

    // Gating with the valid flag keeps outputs at zero while empty or in
    // reset, since the storage array itself holds stale data.
    assign bus.out_reg_write = ~empty & head_entry.reg_write;
    assign bus.out_rd        = empty ? '0 : head_entry.rd;
    assign bus.out_result    = empty ? '0 : head_result;

    assign bus.fwd_valid = bus.out_valid & bus.out_reg_write;
    assign bus.fwd_rd    = bus.out_rd;
    assign bus.fwd_data  = bus.out_result;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.in_valid && full && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomised and directed bench for mem_wb_pipe, checked every cycle
// against a queue-based model of the stage.
module tb_mem_wb_pipe;
    import mem_wb_pipe_pkg::*;

    localparam int DEPTH       = 2;
    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    typedef struct {
        logic                  rw;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       res;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;

    mem_wb_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

    mem_wb_pipe #(
        .DEPTH       (DEPTH),
        .XLEN        (XLEN),
        .REG_ADDR_W  (REG_ADDR_W),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   m_stall;
    int   n_checks;
    int   n_errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] resolve(input int src, input logic [XLEN-1:0] mem_v,
                                                input logic [XLEN-1:0] alu_v, input logic [XLEN-1:0] pc4_v);
        if (src == 0) return alu_v;
        if (src == 1) return mem_v;
        if (src == 2) return pc4_v;
        return '0;
    endfunction

    // Model update: what the stage must do at each rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_stall = 0;
        end else begin
            bit can_in, do_push, do_pop;
            exp_t e;
            can_in  = (exp_q.size() != DEPTH);
            do_push = bus.in_valid && can_in;
            do_pop  = (exp_q.size() != 0) && bus.out_ready;
            if (bus.in_valid && !can_in && m_stall < STALL_MAX) m_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    e.rw  = bus.in_reg_write && (bus.in_rd != 0);
                    e.rd  = bus.in_rd;
                    e.res = resolve(int'(bus.in_result_src), bus.in_read_data,
                                    bus.in_alu_result, bus.in_pc_plus4);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Compare process: DUT outputs depend only on stored state, so the
    // falling edge is a stable point to check them.
    always @(negedge clk) begin
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        chk("in_ready", bus.in_ready, exp_q.size() != DEPTH);
        chk("stall_cnt", stall_cnt, m_stall);
        if (!reset) begin
            chk("rst_out_rd", bus.out_rd, 0);
            chk("rst_out_result", bus.out_result, 0);
            chk("rst_out_reg_write", bus.out_reg_write, 0);
        end
        if (exp_q.size() != 0) begin
            chk("out_rd", bus.out_rd, exp_q[0].rd);
            chk("out_reg_write", bus.out_reg_write, exp_q[0].rw);
            chk("out_result", bus.out_result, exp_q[0].res);
            chk("fwd_valid", bus.fwd_valid, exp_q[0].rw);
            chk("fwd_rd", bus.fwd_rd, exp_q[0].rd);
            chk("fwd_data", bus.fwd_data, exp_q[0].res);
        end else begin
            chk("fwd_valid_idle", bus.fwd_valid, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int src, input logic rw, input logic [XLEN-1:0] mem_v,
                         input logic [XLEN-1:0] alu_v, input logic [XLEN-1:0] pc4_v,
                         input logic [REG_ADDR_W-1:0] rd);
        bus.in_valid      = v;
        bus.in_result_src = result_src_t'(src[1:0]);
        bus.in_reg_write  = rw;
        bus.in_read_data  = mem_v;
        bus.in_alu_result = alu_v;
        bus.in_pc_plus4   = pc4_v;
        bus.in_rd         = rd;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_stall = 0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_stall", stall_cnt, 0);
        chk("async_rst_in_ready", bus.in_ready, 1);
        idle();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        m_stall  = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        step(3);
        reset = 1'b1;

        // Idle after reset, then a single ALU entry.
        step(1);
        chk("t1_idle_valid", bus.out_valid, 0);
        chk("t1_idle_ready", bus.in_ready, 1);
        chk("t1_idle_stall", stall_cnt, 0);
        drive(1'b1, 0, 1'b1, '0, 32'h1234, '0, 5'd5);
        step(1);
        idle();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_result", bus.out_result, 32'h1234);
        chk("t1_fwd_valid", bus.fwd_valid, 1);
        chk("t1_fwd_rd", bus.fwd_rd, 5);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;

        // Fill to capacity, stall the third, then drain in order.
        do_reset();
        drive(1'b1, 0, 1'b1, '0, 32'h11, '0, 5'd1);
        step(1);
        drive(1'b1, 0, 1'b1, '0, 32'h22, '0, 5'd2);
        step(1);
        chk("t2_full_ready", bus.in_ready, 0);
        drive(1'b1, 0, 1'b1, '0, 32'h33, '0, 5'd3);
        step(1);
        chk("t2_stall_one", stall_cnt, 1);
        chk("t2_head_rd1", bus.out_rd, 1);
        bus.out_ready = 1'b1;
        step(1);
        chk("t2_head_rd2", bus.out_rd, 2);
        step(1);
        idle();
        chk("t2_head_rd3", bus.out_rd, 3);
        chk("t2_head_res3", bus.out_result, 32'h33);
        step(1);
        bus.out_ready = 1'b0;

        // Load data, link value, x0 target and an undefined source select.
        drive(1'b1, 1, 1'b1, 32'hDEADBEEF, 32'h5, 32'h9, 5'd7);
        step(1);
        drive(1'b1, 2, 1'b1, 32'h6, 32'h7, 32'h104, 5'd1);
        step(1);
        idle();
        chk("t3_mem_result", bus.out_result, 32'hDEADBEEF);
        bus.out_ready = 1'b1;
        step(1);
        chk("t3_pc4_result", bus.out_result, 32'h104);
        step(1);
        bus.out_ready = 1'b0;
        drive(1'b1, 0, 1'b1, '0, 32'hFF, '0, 5'd0);
        step(1);
        drive(1'b1, 3, 1'b1, 32'hAA, 32'hBB, 32'hCC, 5'd9);
        step(1);
        idle();
        chk("t4_x0_valid", bus.out_valid, 1);
        chk("t4_x0_reg_write", bus.out_reg_write, 0);
        chk("t4_x0_fwd_valid", bus.fwd_valid, 0);
        bus.out_ready = 1'b1;
        step(1);
        chk("t4_bad_src_result", bus.out_result, 0);
        step(1);
        bus.out_ready = 1'b0;

        // Flush with a simultaneous push; the pushed entry must vanish.
        do_reset();
        drive(1'b1, 0, 1'b1, '0, 32'hA1, '0, 5'd9);
        step(1);
        drive(1'b1, 0, 1'b1, '0, 32'hA2, '0, 5'd10);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        idle();
        chk("t5_flush_valid", bus.out_valid, 0);
        chk("t5_flush_stall", stall_cnt, 0);
        bus.out_ready = 1'b1;
        step(3);
        chk("t5_never_emitted", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        drive(1'b1, 0, 1'b1, '0, 32'hB1, '0, 5'd11);
        step(1);
        drive(1'b1, 0, 1'b1, '0, 32'hB2, '0, 5'd12);
        step(1);
        drive(1'b1, 0, 1'b1, '0, 32'hB3, '0, 5'd13);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        idle();
        step(2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int src;
            logic [REG_ADDR_W-1:0] rd;
            src = $urandom_range(0, 3);
            rd  = ($urandom_range(0, 5) == 0) ? '0 : REG_ADDR_W'($urandom_range(1, 31));
            drive($urandom_range(0, 3) != 0, src, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, rd);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            step(1);
        end
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b0;
        step(2);

        // Long back-pressure run to saturation, then reset mid-run.
        drive(1'b1, 0, 1'b1, '0, 32'h77, '0, 5'd4);
        step(STALL_MAX + 70);
        chk("t6_stall_saturated", stall_cnt, 16'hFFFF);
        chk("t6_full_valid", bus.out_valid, 1);
        do_reset();
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
